// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dmem_pkg;

    // Load/store width encodings taken from instr[14:12]
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the wait-state counter (WAIT_CYCLES up to 15)
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: store byte-enables/lane replication, load extraction/extension, error flags.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever access is presented.
// Ports: funct3/addr_lo/we/wdata/rd_word in; be, wr_word, ld_data, misalign, illegal out.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian: lane 0 is the least significant byte of the word
    assign byte_sel = rd_word[8*addr_lo +: 8];
    assign half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        be       = '0;
        wr_word  = '0;
        ld_data  = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        if (we) begin
            // Sub-word data is replicated across lanes; the byte-enable picks the lane(s)
            unique case (funct3)
                F3_B: begin
                    be      = 4'b0001 << addr_lo;
                    wr_word = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wr_word  = {2{wdata[15:0]}};
                    misalign = addr_lo[0];
                end
                F3_W: begin
                    be       = 4'b1111;
                    wr_word  = wdata;
                    misalign = (addr_lo != 2'b00);
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_B:  ld_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU: ld_data = {24'h0, byte_sel};
                F3_H: begin
                    ld_data  = {{16{half_sel[15]}}, half_sel};
                    misalign = addr_lo[0];
                end
                F3_HU: begin
                    ld_data  = {16'h0, half_sel};
                    misalign = addr_lo[0];
                end
                F3_W: begin
                    ld_data  = rd_word;
                    misalign = (addr_lo != 2'b00);
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with valid/ready request port and one-cycle response strobe.
// Latency: accept at end of cycle 0 -> rsp_valid in cycle WAIT_CYCLES+1; ready again one cycle later.
// Backpressure: req_ready low from acceptance through the response cycle; response cannot be stalled.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata;
//        rsp_valid/rsp_rdata/rsp_err (rdata/err hold until the next response).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int                AW        = $clog2(DEPTH_WORDS);
    localparam logic [30:0]       DEPTH_L   = 31'(DEPTH_WORDS);
    localparam logic [WCNT_W-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    logic [31:0] mem [DEPTH_WORDS];

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic              cap_we;
    logic [2:0]        cap_funct3;
    logic [31:0]       cap_addr;
    logic [31:0]       cap_wdata;

    logic        accept;
    logic        enter_resp;
    logic        use_live;
    logic        acc_we;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [3:0]  be;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic        misalign;
    logic        illegal;
    logic        out_of_range;
    logic        acc_err;

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the access happens on the accepting edge itself, so the
    // live request is used; otherwise the captured copy drives the access.
    assign use_live   = (state_q == IDLE);
    assign acc_we     = use_live ? req_we     : cap_we;
    assign acc_funct3 = use_live ? req_funct3 : cap_funct3;
    assign acc_addr   = use_live ? req_addr   : cap_addr;
    assign acc_wdata  = use_live ? req_wdata  : cap_wdata;

    assign idx          = acc_addr[AW+1:2];
    assign rd_word      = mem[idx];
    assign out_of_range = ({1'b0, acc_addr[31:2]} >= DEPTH_L);
    assign acc_err      = out_of_range || misalign || illegal;

    dmem_align u_align (
        .funct3   (acc_funct3),
        .addr_lo  (acc_addr[1:0]),
        .we       (acc_we),
        .wdata    (acc_wdata),
        .rd_word  (rd_word),
        .be       (be),
        .wr_word  (wr_word),
        .ld_data  (ld_data),
        .misalign (misalign),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wcnt_q <= WAIT_INIT;
            end else if (state_q == WAIT && wcnt_q != '0) begin
                wcnt_q <= wcnt_q - 1'b1;
            end
            if (enter_resp) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? '0 : ld_data;
            end
        end
    end

    // Request capture needs no reset: it is only consumed after a fresh accept
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
        end
    end

    // Array is never cleared; a reset on the commit edge cancels the pending store
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && !acc_err) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) begin
                    mem[idx][8*l +: 8] <= wr_word[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: zero-wait instance for data path, three-wait instance for timing/reset.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen high.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v0, rdy0, we0, rv0, err0;
    logic [2:0]  f3_0;
    logic [31:0] a0, wd0, rd0;

    logic        v3, rdy3, we3, rv3, err3;
    logic [2:0]  f3_3;
    logic [31:0] a3, wd3, rd3;

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_funct3(f3_0),
        .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
    );

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(rdy3), .req_we(we3), .req_funct3(f3_3),
        .req_addr(a3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
    );

    int compared   = 0;
    int mismatched = 0;

    // Expected responses as {err, rdata}
    logic [32:0] q0[$];
    logic [32:0] q3[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        int n;
        if (sel) begin
            q3.push_back({exp_err, exp_rd});
            v3 = 1'b1; we3 = we; f3_3 = f3; a3 = addr; wd3 = wd;
        end else begin
            q0.push_back({exp_err, exp_rd});
            v0 = 1'b1; we0 = we; f3_0 = f3; a0 = addr; wd0 = wd;
        end
        n = 0;
        while (!(sel ? rdy3 : rdy0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout dut%0d addr %h: ready never seen", sel ? 3 : 0, addr);
        end
        @(posedge clk); #1;
        if (sel) v3 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_ready3();
        int n;
        n = 0;
        while (!rdy3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL ready3_timeout: got ready=%b want 1", rdy3);
        end
    endtask

    // Monitor: every response strobe is matched against the head of its queue
    always @(negedge clk) begin
        logic [32:0] e;
        if (rv0 === 1'b1) begin
            compared++;
            if (q0.size() == 0) begin
                mismatched++;
                $display("FAIL rsp0_unexpected: got err=%b rdata=%h want no response", err0, rd0);
            end else begin
                e = q0.pop_front();
                if ({err0, rd0} !== e) begin
                    mismatched++;
                    $display("FAIL rsp0: got err=%b rdata=%h want err=%b rdata=%h",
                             err0, rd0, e[32], e[31:0]);
                end
            end
        end
        if (rv3 === 1'b1) begin
            compared++;
            if (q3.size() == 0) begin
                mismatched++;
                $display("FAIL rsp3_unexpected: got err=%b rdata=%h want no response", err3, rd3);
            end else begin
                e = q3.pop_front();
                if ({err3, rd3} !== e) begin
                    mismatched++;
                    $display("FAIL rsp3: got err=%b rdata=%h want err=%b rdata=%h",
                             err3, rd3, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        v0 = 1'b0; we0 = 1'b0; f3_0 = '0; a0 = '0; wd0 = '0;
        v3 = 1'b0; we3 = 1'b0; f3_3 = '0; a3 = '0; wd3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0", 32'(rdy0), 32'd1);
        chk("reset_valid0", 32'(rv0),  32'd0);
        chk("reset_rdata0", rd0,       32'd0);
        chk("reset_err0",   32'(err0), 32'd0);
        chk("reset_ready3", 32'(rdy3), 32'd1);
        chk("reset_valid3", 32'(rv3),  32'd0);
        chk("reset_rdata3", rd3,       32'd0);
        chk("reset_err3",   32'(err3), 32'd0);
        rst = 1'b0;

        // Data path on the zero-wait instance
        issue(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0);
        issue(0, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0);
        issue(0, 1, F3_B,  32'h11, 32'h123456AB, 32'h0,        0);
        issue(0, 0, F3_W,  32'h10, 32'h0,        32'hDEADABEF, 0);
        issue(0, 0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 0);
        issue(0, 0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 0);
        issue(0, 0, F3_B,  32'h11, 32'h0,        32'hFFFFFFAB, 0);
        issue(0, 0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 0);
        issue(0, 1, F3_W,  32'h20, 32'h0,        32'h0,        0);
        issue(0, 1, F3_B,  32'h20, 32'hFFFFFF80, 32'h0,        0);
        issue(0, 0, F3_B,  32'h20, 32'h0,        32'hFFFFFF80, 0);
        issue(0, 0, F3_BU, 32'h20, 32'h0,        32'h00000080, 0);
        issue(0, 1, F3_H,  32'h22, 32'h5555BEEF, 32'h0,        0);
        issue(0, 0, F3_W,  32'h20, 32'h0,        32'hBEEF0080, 0);
        issue(0, 0, F3_H,  32'h22, 32'h0,        32'hFFFFBEEF, 0);
        issue(0, 0, F3_H,  32'h20, 32'h0,        32'h00000080, 0);
        // Errors: misaligned, illegal funct3, out of range; memory must stay intact
        issue(0, 1, F3_W,  32'h00, 32'h55AA55AA, 32'h0,        0);
        issue(0, 1, F3_H,  32'h03, 32'h00001234, 32'h0,        1);
        issue(0, 0, F3_W,  32'h00, 32'h0,        32'h55AA55AA, 0);
        issue(0, 1, F3_W,  32'h02, 32'hFFFFFFFF, 32'h0,        1);
        issue(0, 1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0,       1);
        issue(0, 0, F3_W,  32'h00, 32'h0,        32'h55AA55AA, 0);
        issue(0, 0, F3_W,  32'h400, 32'h0,       32'h0,        1);
        issue(0, 0, 3'b011, 32'h00, 32'h0,       32'h0,        1);
        issue(0, 0, 3'b110, 32'h00, 32'h0,       32'h0,        1);
        issue(0, 0, F3_HU, 32'h01, 32'h0,        32'h0,        1);
        issue(0, 0, F3_W,  32'h11, 32'h0,        32'h0,        1);
        // Top word of the array, then just past it (aliases word 0 in low bits)
        issue(0, 1, F3_W,  32'h3FC, 32'hCAFEF00D, 32'h0,       0);
        issue(0, 0, F3_W,  32'h3FC, 32'h0,       32'hCAFEF00D, 0);
        issue(0, 0, F3_BU, 32'h3FF, 32'h0,       32'h000000CA, 0);
        issue(0, 1, F3_B,  32'h400, 32'h000000FF, 32'h0,       1);
        issue(0, 0, F3_W,  32'hFFFFFFFC, 32'h0,  32'h0,        1);
        issue(0, 0, F3_W,  32'h00, 32'h0,        32'h55AA55AA, 0);

        // Three-wait instance: seed a value
        issue(1, 1, F3_W,  32'h40, 32'h22222222, 32'h0,        0);
        issue(1, 0, F3_W,  32'h40, 32'h0,        32'h22222222, 0);
        wait_ready3();

        // Timing: accept at end of cycle 0, request held through the busy window
        q3.push_back({1'b0, 32'h22222222});
        q3.push_back({1'b0, 32'h22222222});
        v3 = 1'b1; we3 = 1'b0; f3_3 = F3_W; a3 = 32'h40; wd3 = 32'h0;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("timing_valid_c%0d", c), 32'(rv3),  32'(c == 4));
            chk($sformatf("timing_ready_c%0d", c), 32'(rdy3), 32'(c >= 5));
            @(posedge clk);
        end
        #1;
        v3 = 1'b0;
        chk("held_req_accepted_c5", 32'(rdy3), 32'd0);
        wait_ready3();

        // Reset during WAIT discards a pending store
        v3 = 1'b1; we3 = 1'b1; f3_3 = F3_W; a3 = 32'h40; wd3 = 32'h11111111;
        @(posedge clk); #1;
        v3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready3", 32'(rdy3), 32'd1);
        chk("midrst_valid3", 32'(rv3),  32'd0);
        chk("midrst_rdata3", rd3,       32'd0);
        repeat (6) @(posedge clk);
        #1;
        issue(1, 0, F3_W,  32'h40, 32'h0,        32'h22222222, 0);
        // Array contents survive reset
        issue(0, 0, F3_W,  32'h10, 32'h0,        32'hDEADABEF, 0);

        n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        compared++;
        if (q0.size() != 0 || q3.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d responses outstanding want 0/0", q0.size(), q3.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised byte-addressable data memory for the single-cycle/multi-cycle CPU datapath.
- Successor to the flat word-indexed data memory, with these additions:
  - true byte lanes and little-endian sub-word stores;
  - RISC-V-correct load sign/zero extension;
  - misalignment, range and illegal-funct3 error reporting;
  - a valid/ready request port with configurable wait states to model slow memory.
- Sits between the ALU address output and the writeback mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; byte address space is DEPTH_WORDS*4.
- WAIT_CYCLES, 0, extra access wait states (0..15) between acceptance and response.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instr[14:12].
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for sb/sh.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  access rejected (misaligned, out of range, or illegal funct3).

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready, capture we, funct3, addr and wdata. Next state is WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: req_ready = 0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0, next state is RESP.
  - RESP: req_ready = 0; rsp_valid = 1 for exactly one cycle; next state is IDLE.
  - No backpressure on the response. There is no accept in RESP.
- Latency and throughput:
  - Request accepted at the end of cycle 0 gives rsp_valid high in cycle WAIT_CYCLES+1.
  - req_ready returns high in cycle WAIT_CYCLES+2.
- Access timing:
  - The memory access happens at the clock edge entering RESP: the store commits and the load data registers into rsp_rdata.
  - A load issued after a store completes returns the new data.
- Load funct3 encoding:
  - 000 lb: sign-extend byte addr[1:0].
  - 001 lh: sign-extend half addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 011, 110, 111: illegal.
- Store funct3 encoding:
  - 000 sb: writes the single lane addr[1:0] with wdata[7:0].
  - 001 sh: writes lanes {addr[1],0}..+1 with wdata[15:0].
  - 010 sw: writes all 4 lanes.
  - Any other value: illegal.
  - Unwritten lanes of the word are preserved.
- Misalignment rules:
  - Half access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
- Range rule: addr >= DEPTH_WORDS*4 is out of range. Word index is addr[31:2].
- Error response (any of the three error conditions):
  - rsp_err = 1, rsp_rdata = 0.
  - No memory bit changes.
  - Timing is identical to a good access.
- Non-error response: rsp_err = 0. A store's rsp_rdata = 0.
- rsp_rdata and rsp_err hold their values after RESP until the next RESP; only rsp_valid qualifies them.
- Reset mid-operation (rst in WAIT or RESP): the captured request is discarded. A store that had not yet committed must not write. Return to IDLE.
- req_valid while req_ready = 0 is ignored; the requester must hold it.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM state enum {IDLE, WAIT, RESP};
  - WAIT counter width constant (4).
- Sub-module dmem_align (combinational):
  - inputs funct3, addr[1:0], we, wdata, and the read word;
  - outputs 4-bit byte-enable, lane-shifted write word, extended load data, and the misalign/illegal flags.
- dmem_ctrl holds the FSM, capture registers and the array.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- After the above, sb 0xAB @0x11, then lw @0x10 -> 0xDEADABEF; lhu @0x12 -> 0x0000DEAD; lh @0x12 -> 0xFFFFDEAD.
- sb 0x80 @0x20, then lb @0x20 -> 0xFFFFFF80; lbu @0x20 -> 0x00000080.
- sh 0x1234 @0x03 -> rsp_err = 1; lw @0x00 unchanged. lw @0x400 with DEPTH_WORDS = 256 -> rsp_err = 1, rsp_rdata = 0. funct3 = 011 -> rsp_err = 1.
- WAIT_CYCLES = 3: accept at cycle 0 -> rsp_valid only in cycle 4, req_ready low in cycles 1-4, high in cycle 5. A req_valid held during busy is accepted in cycle 5.
- WAIT_CYCLES = 3: sw 0x11111111 @0x40, rst pulsed in cycle 2 -> no rsp_valid, req_ready = 1 after reset, lw @0x40 returns the prior value.
